// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: majority-voted bits, optional parity,
// one or two stop bits, valid/ready delivery with a sticky overrun flag.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] S_LO  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] S_MID = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] S_HI  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);
    localparam logic ODD = (PARITY == 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PAR       = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic valid_q, valid_d, operr_q, operr_d;
    logic oferr_q, oferr_d, ovr_q, ovr_d;
    logic vote, commit, wrap, deliver;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        valid_d = valid_q;
        operr_d = operr_q;
        oferr_d = oferr_q;
        ovr_d   = ovr_q;
        deliver = 1'b0;
        vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) |
                  (smp_q[1] & rx_s_q);
        commit  = (cnt_q == S_HI);
        wrap    = (cnt_q == C_END);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        if (cnt_q == S_LO)  smp_d[0] = rx_s_q;
        if (cnt_q == S_MID) smp_d[1] = rx_s_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // cnt reads 0 in the edge cycle, so it is 1 one cycle later
                if (!rx_s_q && rx_prev_q) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (commit && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (commit) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (idx_q == D_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (commit) perr_d = vote != ((^shift_q) ^ ODD);
                if (wrap) state_d = STOP;
            end
            STOP: begin
                if (commit && !vote) ferr_d = 1'b1;
                if (commit && idx_q == S_LAST) begin
                    deliver = 1'b1;
                    cnt_d   = '0;
                    state_d = (ferr_q || !vote) ? WAIT_IDLE : IDLE;
                end else if (wrap) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                operr_d = perr_q;
                oferr_d = ferr_q | ~vote;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            operr_q   <= 1'b0;
            oferr_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            operr_q   <= operr_d;
            oferr_q   <= oferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = operr_q;
    assign frame_err  = oferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance at 16 clocks per bit,
// a frame-level delivery model checked every cycle, plus literal pins.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] rxv, rdy, v, pe, fe, ov, bz;
    logic [7:0] d0;
    logic [6:0] d1;
    longint cyc = 0;
    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int dut;
        longint due;
        logic [8:0] dat;
        logic pe;
        logic fe;
    } ev_t;
    ev_t evq[$];

    logic mval[2], mpe[2], mfe[2], movr[2], vprev[2];
    logic [8:0] mdat[2];
    logic rst_p;
    logic [1:0] rdy_p;
    longint rise[2];
    logic [8:0] rdat[2];
    logic rpe[2], rfe[2];
    int nrise[2];

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1)) u8 (
        .clk(clk), .rst(rst), .rx(rxv[0]), .data_out(d0), .valid(v[0]),
        .ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .overrun(ov[0]), .busy(bz[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2)) u7 (
        .clk(clk), .rst(rst), .rx(rxv[1]), .data_out(d1), .valid(v[1]),
        .ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .overrun(ov[1]), .busy(bz[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one whole frame; queues the word the receiver must deliver.
    task automatic send(input int i, input logic [8:0] w, input bit flip,
                        input bit badstop, input int gk);
        int nd, np, ns, n;
        logic [8:0] mask;
        logic b;
        ev_t e;
        nd = (i == 0) ? 8 : 7;
        np = i;
        ns = (i == 0) ? 1 : 2;
        n = nd + np + ns;
        mask = (i == 0) ? 9'h0FF : 9'h07F;
        e.dut = i;
        e.due = cyc + 4 + n * 16 + 8;
        e.dat = w & mask;
        e.pe = (np != 0) && flip;
        e.fe = badstop;
        evq.push_back(e);
        for (int k = 0; k <= n; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= nd) b = w[k-1];
            else if (np != 0 && k == nd + 1) b = (^(w & mask)) ^ flip;
            else b = !badstop;
            for (int c = 0; c < 16; c++) begin
                rxv[i] = (k == gk && c == 8) ? !b : b;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [8:0] dd;
        logic hs;
        for (int i = 0; i < 2; i++) begin
            mval[i] = 0; mpe[i] = 0; mfe[i] = 0; movr[i] = 0;
            mdat[i] = 0; vprev[i] = 0; rise[i] = 0; rdat[i] = 0;
            rpe[i] = 0; rfe[i] = 0; nrise[i] = 0;
        end
        rst_p = 1'b1;
        rdy_p = 2'b11;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                dd = (i == 0) ? {1'b0, d0} : {2'b00, d1};
                if (rst_p) begin
                    mval[i] = 0; mdat[i] = 0; mpe[i] = 0;
                    mfe[i] = 0; movr[i] = 0;
                end else begin
                    hs = mval[i] && rdy_p[i];
                    if (hs) mval[i] = 0;
                    for (int j = evq.size() - 1; j >= 0; j--) begin
                        if (evq[j].dut == i && evq[j].due == cyc) begin
                            if (mval[i] && !hs) begin
                                movr[i] = 1;
                            end else begin
                                mval[i] = 1;
                                mdat[i] = evq[j].dat;
                                mpe[i] = evq[j].pe;
                                mfe[i] = evq[j].fe;
                            end
                            evq.delete(j);
                        end
                    end
                end
                chk($sformatf("u%0d valid", i), v[i], mval[i]);
                chk($sformatf("u%0d overrun", i), ov[i], movr[i]);
                if (mval[i]) begin
                    chk($sformatf("u%0d data_out", i), dd, mdat[i]);
                    chk($sformatf("u%0d parity_err", i), pe[i], mpe[i]);
                    chk($sformatf("u%0d frame_err", i), fe[i], mfe[i]);
                end
                if (v[i] && !vprev[i]) begin
                    rise[i] = cyc;
                    rdat[i] = dd;
                    rpe[i] = pe[i];
                    rfe[i] = fe[i];
                    nrise[i]++;
                end
                vprev[i] = v[i];
            end
            rst_p = rst;
            rdy_p = rdy;
        end
    end

    initial begin
        longint p;
        int bc, nr;
        rxv = 2'b11;
        rdy = 2'b11;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("reset valid", v, 0);
        chk("reset busy", bz, 0);
        chk("reset overrun", ov, 0);
        chk("reset data u8", d0, 0);
        chk("reset data u7", d1, 0);
        idle(20);

        p = cyc;
        send(0, 9'h0A5, 0, 0, -1);
        idle(20);
        chk("8n1 latency", rise[0] - p, 156);
        chk("8n1 data", rdat[0], 9'h0A5);
        chk("8n1 perr", rpe[0], 0);
        chk("8n1 ferr", rfe[0], 0);
        chk("8n1 overrun", ov[0], 0);

        p = cyc;
        send(1, 9'h05A, 0, 0, -1);
        idle(20);
        chk("7e2 latency", rise[1] - p, 172);
        chk("7e2 data", rdat[1], 9'h05A);
        chk("7e2 perr ok", rpe[1], 0);
        send(1, 9'h05A, 1, 0, -1);
        idle(20);
        chk("7e2 data flip", rdat[1], 9'h05A);
        chk("7e2 perr flip", rpe[1], 1);

        nr = nrise[0];
        rxv[0] = 1'b0;
        idle(3);
        rxv[0] = 1'b1;
        bc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bc += int'(bz[0]);
        end
        idle(1);
        chk("false start busy cycles", bc, 9);
        chk("false start no word", nrise[0], nr);
        idle(20);

        p = cyc;
        send(0, 9'h000, 0, 0, 4);
        idle(20);
        chk("glitch latency", rise[0] - p, 156);
        chk("glitch data", rdat[0], 9'h000);

        send(0, 9'h081, 0, 1, -1);
        idle(40);
        chk("break busy", bz[0], 1);
        chk("break ferr", rfe[0], 1);
        chk("break data", rdat[0], 9'h081);
        rxv[0] = 1'b1;
        idle(10);
        chk("break release busy", bz[0], 0);
        p = cyc;
        send(0, 9'h03C, 0, 0, -1);
        idle(20);
        chk("after break latency", rise[0] - p, 156);
        chk("after break data", rdat[0], 9'h03C);
        chk("after break ferr", rfe[0], 0);

        rdy[0] = 1'b0;
        send(0, 9'h011, 0, 0, -1);
        send(0, 9'h022, 0, 0, -1);
        idle(20);
        chk("overrun held data", d0, 8'h11);
        chk("overrun flag", ov[0], 1);
        chk("overrun valid", v[0], 1);
        rdy[0] = 1'b1;
        idle(2);
        chk("overrun drained", v[0], 0);

        nr = nrise[0];
        rxv[0] = 1'b0;
        idle(16);
        rxv[0] = 1'b1;
        idle(4 * 16 + 8);
        chk("mid-frame busy", bz[0], 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(200);
        chk("mid rst valid", v[0], 0);
        chk("mid rst overrun", ov[0], 0);
        chk("mid rst busy", bz[0], 0);
        chk("mid rst data", d0, 0);
        chk("mid rst flags", {pe[0], fe[0]}, 0);
        chk("mid rst no word", nrise[0], nr);
        p = cyc;
        send(0, 9'h0C3, 0, 0, -1);
        idle(20);
        chk("post rst latency", rise[0] - p, 156);
        chk("post rst data", rdat[0], 9'h0C3);

        rdy[0] = 1'b0;
        fork
            begin
                send(0, 9'h011, 0, 0, -1);
                send(0, 9'h022, 0, 0, -1);
            end
            begin
                idle(315);
                rdy[0] = 1'b1;
                idle(1);
                rdy[0] = 1'b0;
            end
        join
        idle(20);
        chk("ready pulse data", d0, 8'h22);
        chk("ready pulse overrun", ov[0], 0);
        chk("ready pulse valid", v[0], 1);
        rdy[0] = 1'b1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. Data width, parity mode, stop-bit count and bit period are set at elaboration. The bit timer re-aligns to every start edge, and each bit is decided by a 3-sample majority vote. A received word is delivered on a valid/ready handshake with per-word parity and framing flags, and a sticky overrun flag reports dropped words. It sits between the pad-side `rx` line and the command/byte consumer in the same clock domain.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per bit period; legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idle high.
- `data_out`  out  DATA_BITS  received word, LSB = first data bit on the wire.
- `valid`  out  1  `data_out`, `parity_err` and `frame_err` hold a word.
- `ready`  in  1  consumer accepts the word when `valid && ready`.
- `parity_err`  out  1  parity mismatch on the held word; always 0 when `PARITY == 0`.
- `frame_err`  out  1  a stop bit of the held word was decided 0.
- `overrun`  out  1  sticky; a completed frame was dropped because `valid` was still high.
- `busy`  out  1  high from start-edge detection until return to IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops (reset value 1); the result is `rx_s`. All logic uses `rx_s`.
- **States:**
  - IDLE, START, DATA, PAR (skipped when `PARITY == 0`), STOP, WAIT_IDLE.
  - Illegal encodings go to IDLE.
- **Bit timer:**
  - `cnt` runs 0..`CLKS_PER_BIT`-1 and is forced to 0 on the start edge.
  - Let H = `CLKS_PER_BIT`/2 (integer division).
  - Samples are taken at `cnt` = H-1, H and H+1. The bit value is the majority of the three and is committed at `cnt` = H+1.
- **IDLE:**
  - Goes to START when `rx_s` is 0 and was 1 the previous cycle. Call this cycle T0.
  - A low level without a falling edge does not start a frame.
- **START:** if the majority decision is 1, this is a false start and the block returns to IDLE with no output. Otherwise it goes to DATA at the next period boundary.
- **DATA:** shifts `DATA_BITS` bits in, LSB first.
- **PAR:**
  - Computed bit = XOR of the data bits (even) or its inverse (odd).
  - `parity_err` = received bit ≠ computed bit.
- **STOP:**
  - Decides `STOP_BITS` bits. Any stop bit decided 0 sets `frame_err`.
  - On commit of the last stop bit the word is delivered.
  - If the last stop bit was 1, go straight to IDLE in the same cycle, mid-bit. No wait for the period end.
  - If `frame_err`, go to WAIT_IDLE.
- **WAIT_IDLE:** stays until `rx_s` is 1 (break handling), then goes to IDLE.
- **Delivery:**
  - If `valid` is 0, or `valid && ready` in the delivery cycle: load `data_out`, `parity_err` and `frame_err`, and set `valid`.
  - Otherwise: drop the new word, set `overrun`, and leave the held word unchanged.
- **Handshake:**
  - `valid` stays high, with outputs stable, until the cycle after `valid && ready`.
  - `ready` while `valid` is low has no effect.
- **overrun:** cleared only by `rst`.
- **Reset:**
  - Outputs: `valid`, `data_out`, `parity_err`, `frame_err`, `overrun` and `busy` all go to 0.
  - Internals: state = IDLE, `cnt` = 0, synchronizer flops = 1.
  - Reset mid-frame abandons the frame. No partial word is delivered.

## Timing
- Bit k (k = 0 is the start bit) has its centre at T0 + k·`CLKS_PER_BIT` + H.
- Let N = `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS`, the index of the last stop bit.
- `valid` rises at T0 + N·`CLKS_PER_BIT` + H + 2.
- `rx` to `rx_s` latency is 2 cycles.
- `busy` is 1 from T0+1 through the cycle the FSM leaves STOP or WAIT_IDLE.
- Back-to-back frames (the next start edge right after the final stop bit) are received with no loss.
- A falling edge during the final stop bit, after the commit, is a valid new start.
- Throughput: one word per frame time. The consumer must accept within one frame time to avoid overrun.

## Test plan
- **8N1 single word:** `CLKS_PER_BIT`=16, 8N1, send 0xA5 → `valid` at T0+9·16+10; `data_out`=0xA5, `parity_err`=0, `frame_err`=0, `overrun`=0.
- **Even parity, 7 data bits, 2 stop bits:**
  - Send 0x5A with a correct parity bit → `data_out`=0x5A, `parity_err`=0.
  - Repeat with the parity bit flipped → `parity_err`=1.
- **Glitch rejection:**
  - A 3-cycle low pulse on idle `rx` → START then back to IDLE, no `valid`, `busy` pulses.
  - A 1-cycle inverted glitch at the centre of data bit 3 of 0x00 → `data_out`=0x00.
- **Framing and break:**
  - Stop bit held 0 → `frame_err`=1, word delivered, state held in WAIT_IDLE while `rx`=0 for 40 cycles.
  - Next frame 0x3C after `rx` returns high → received clean.
- **Handshake and overrun:**
  - Two back-to-back frames 0x11, 0x22 with `ready`=0 → `data_out` stays 0x11, `overrun`=1.
  - Repeat with `ready`=1 in the second delivery cycle → `data_out`=0x22, `overrun` stays 0.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 → all outputs 0, no `valid`; the following frame 0xC3 is received correctly.
